// File: rtl/a_pl_hs_nclk.sv
// rtl/a_pl_hs_nclk.sv - elastic DELAY-stage pipeline with valid/ready handshake
//
// Purpose:
//   Delays a stream by DELAY register stages. With no stalls it behaves as a
//   fixed delay line. When ordy drops, words pack towards the output and
//   backpressure reaches irdy combinationally.
//
// Ports:
//   clk    in   1     clock, rising edge
//   rst_n  in   1     asynchronous reset, active low
//   ivld   in   1     upstream data valid
//   irdy   out  1     pipeline can accept idat this cycle
//   idat   in   SIZE  upstream data
//   ovld   out  1     odat valid (last stage occupied)
//   ordy   in   1     downstream accepts odat this cycle
//   odat   out  SIZE  data from last stage
//   ocnt   out  CNTW  number of occupied stages
module a_pl_hs_nclk #(
  parameter int              SIZE    = 8,
  parameter int              DELAY   = 3,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}},
  parameter int              CNTW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ivld,
  output logic            irdy,
  input  logic [SIZE-1:0] idat,
  output logic            ovld,
  input  logic            ordy,
  output logic [SIZE-1:0] odat,
  output logic [CNTW-1:0] ocnt
);

  generate
    if (DELAY == 0) begin : g_pass
      // No storage: the handshake passes straight through.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign irdy = ordy;
      assign ovld = ivld;
      assign odat = idat;
      assign ocnt = '0;
    end else begin : g_pipe
      logic [DELAY-1:0] v_q;
      logic [DELAY-1:0] v_d;
      logic [DELAY-1:0] adv;
      logic [SIZE-1:0]  d_q [DELAY];
      logic [SIZE-1:0]  d_d [DELAY];
      logic [CNTW-1:0]  cnt;

      // A stage may advance unless it and every stage after it are occupied
      // while the consumer stalls; this lets bubbles collapse.
      always_comb begin : p_adv
        logic full_tail;
        full_tail = 1'b1;
        adv       = '0;
        for (int k = DELAY - 1; k >= 0; k--) begin
          full_tail = full_tail & v_q[k];
          adv[k]    = ordy | ~full_tail;
        end
      end

      always_comb begin : p_next
        v_d = v_q;
        for (int k = 0; k < DELAY; k++) begin
          d_d[k] = d_q[k];
        end
        if (adv[0]) begin
          v_d[0] = ivld;
          if (ivld) begin
            d_d[0] = idat;
          end
        end
        for (int k = 1; k < DELAY; k++) begin
          if (adv[k]) begin
            v_d[k] = v_q[k-1];
            // Data only moves with a valid word, so empty stages keep old data.
            if (v_q[k-1]) begin
              d_d[k] = d_q[k-1];
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int k = 0; k < DELAY; k++) begin
            d_q[k] <= RST_VAL;
          end
        end else begin
          v_q <= v_d;
          for (int k = 0; k < DELAY; k++) begin
            d_q[k] <= d_d[k];
          end
        end
      end

      always_comb begin : p_cnt
        cnt = '0;
        for (int k = 0; k < DELAY; k++) begin
          cnt = cnt + CNTW'(v_q[k]);
        end
      end

      assign irdy = adv[0];
      assign ovld = v_q[DELAY-1];
      assign odat = d_q[DELAY-1];
      assign ocnt = cnt;
    end
  endgenerate

endmodule

// File: tb/tb_a_pl_hs_nclk.sv
// tb/tb_a_pl_hs_nclk.sv - directed vector bench for a_pl_hs_nclk
module tb_a_pl_hs_nclk;

  typedef struct {
    logic       rst_n;
    logic       ivld;
    logic [7:0] idat;
    logic       ordy;
    logic       irdy;
    logic       ovld;
    logic [7:0] odat;
    logic [1:0] ocnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       ivld = 1'b0, ordy = 1'b0, irdy, ovld;
  logic [7:0] idat = 8'h00, odat;
  logic [1:0] ocnt;

  logic       i1_ivld = 1'b0, i1_ordy = 1'b0, i1_irdy, i1_ovld;
  logic [7:0] i1_idat = 8'h00, i1_odat;
  logic [0:0] i1_ocnt;

  logic       i0_ivld = 1'b0, i0_ordy = 1'b0, i0_irdy, i0_ovld;
  logic [7:0] i0_idat = 8'h00, i0_odat;
  logic [0:0] i0_ocnt;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  a_pl_hs_nclk #(.SIZE(8), .DELAY(3), .RST_VAL(8'h00), .CNTW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .ivld(ivld), .irdy(irdy), .idat(idat),
    .ovld(ovld), .ordy(ordy), .odat(odat), .ocnt(ocnt)
  );

  a_pl_hs_nclk #(.SIZE(8), .DELAY(1), .RST_VAL(8'h00), .CNTW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ivld(i1_ivld), .irdy(i1_irdy), .idat(i1_idat),
    .ovld(i1_ovld), .ordy(i1_ordy), .odat(i1_odat), .ocnt(i1_ocnt)
  );

  a_pl_hs_nclk #(.SIZE(8), .DELAY(0), .RST_VAL(8'h00), .CNTW(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ivld(i0_ivld), .irdy(i0_irdy), .idat(i0_idat),
    .ovld(i0_ovld), .ordy(i0_ordy), .odat(i0_odat), .ocnt(i0_ocnt)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [7:0] id, input logic ordy_i,
                     input logic e_irdy, input logic e_ovld, input logic [7:0] e_odat,
                     input logic [1:0] e_ocnt);
    vec_t t;
    t.rst_n = r; t.ivld = iv; t.idat = id; t.ordy = ordy_i;
    t.irdy = e_irdy; t.ovld = e_ovld; t.odat = e_odat; t.ocnt = e_ocnt;
    vecs.push_back(t);
  endtask

  initial begin
    // reset held, input offered: nothing captured
    add(0, 1, 8'hA5, 1, 1, 0, 8'h00, 0);
    add(0, 1, 8'hA5, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'hA5, 0, 1, 0, 8'h00, 0);
    // streaming 1..5, ordy=1
    add(1, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    add(1, 1, 8'h02, 1, 1, 0, 8'h00, 1);
    add(1, 1, 8'h03, 1, 1, 0, 8'h00, 2);
    add(1, 1, 8'h04, 1, 1, 1, 8'h01, 3);
    add(1, 1, 8'h05, 1, 1, 1, 8'h02, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h03, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h04, 2);
    add(1, 0, 8'h00, 1, 1, 1, 8'h05, 1);
    add(1, 0, 8'h00, 1, 1, 0, 8'h05, 0);
    // fill and stall
    add(1, 1, 8'h11, 0, 1, 0, 8'h05, 0);
    add(1, 1, 8'h22, 0, 1, 0, 8'h05, 1);
    add(1, 1, 8'h33, 0, 1, 0, 8'h05, 2);
    add(1, 1, 8'h44, 0, 0, 1, 8'h11, 3);
    add(1, 1, 8'h44, 0, 0, 1, 8'h11, 3);
    add(1, 1, 8'h44, 1, 1, 1, 8'h11, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h22, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h33, 2);
    add(1, 0, 8'h00, 1, 1, 1, 8'h44, 1);
    // refill, then push and pop at full
    add(1, 1, 8'h51, 0, 1, 0, 8'h44, 0);
    add(1, 1, 8'h52, 0, 1, 0, 8'h44, 1);
    add(1, 1, 8'h53, 0, 1, 0, 8'h44, 2);
    add(1, 1, 8'h61, 1, 1, 1, 8'h51, 3);
    add(1, 1, 8'h62, 1, 1, 1, 8'h52, 3);
    add(1, 1, 8'h63, 1, 1, 1, 8'h53, 3);
    add(1, 1, 8'h64, 1, 1, 1, 8'h61, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h62, 3);
    add(1, 0, 8'h00, 1, 1, 1, 8'h63, 2);
    add(1, 0, 8'h00, 1, 1, 1, 8'h64, 1);
    // bubble collapse with ordy low
    add(1, 1, 8'hA0, 0, 1, 0, 8'h64, 0);
    add(1, 0, 8'h00, 0, 1, 0, 8'h64, 1);
    add(1, 1, 8'hB0, 0, 1, 0, 8'h64, 1);
    add(1, 0, 8'h00, 0, 1, 1, 8'hA0, 2);
    add(1, 0, 8'h00, 0, 1, 1, 8'hA0, 2);
    add(1, 0, 8'h00, 0, 1, 1, 8'hA0, 2);
    add(1, 0, 8'h00, 0, 1, 1, 8'hA0, 2);
    // asynchronous reset with two words in flight, then refill
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
    add(1, 1, 8'h77, 1, 1, 0, 8'h00, 0);
    add(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(1, 0, 8'h00, 1, 1, 0, 8'h00, 1);
    add(1, 0, 8'h00, 1, 1, 1, 8'h77, 1);
    add(1, 0, 8'h00, 1, 1, 0, 8'h77, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      ivld  = vecs[i].ivld;
      idat  = vecs[i].idat;
      ordy  = vecs[i].ordy;
      #1;
      chk("d3_irdy", i, 32'(irdy), 32'(vecs[i].irdy));
      chk("d3_ovld", i, 32'(ovld), 32'(vecs[i].ovld));
      chk("d3_odat", i, 32'(odat), 32'(vecs[i].odat));
      chk("d3_ocnt", i, 32'(ocnt), 32'(vecs[i].ocnt));
    end

    // DELAY=1: one-cycle latency at full throughput
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i1_ivld = 1'b1; i1_idat = 8'(k); i1_ordy = 1'b1;
      #1;
      chk("d1_irdy", k, 32'(i1_irdy), 32'd1);
      chk("d1_ovld", k, 32'(i1_ovld), (k > 1) ? 32'd1 : 32'd0);
      if (k > 1) chk("d1_odat", k, 32'(i1_odat), 32'(k - 1));
    end
    @(negedge clk); i1_ivld = 1'b0; #1;
    chk("d1_ovld", 6, 32'(i1_ovld), 32'd1);
    chk("d1_odat", 6, 32'(i1_odat), 32'h05);
    chk("d1_ocnt", 6, 32'(i1_ocnt), 32'd1);
    @(negedge clk); #1;
    chk("d1_ovld", 7, 32'(i1_ovld), 32'd0);
    chk("d1_ocnt", 7, 32'(i1_ocnt), 32'd0);
    // DELAY=1 stall
    @(negedge clk); i1_ivld = 1'b1; i1_idat = 8'h9C; i1_ordy = 1'b0; #1;
    chk("d1_irdy", 8, 32'(i1_irdy), 32'd1);
    @(negedge clk); i1_idat = 8'h9D; #1;
    chk("d1_irdy", 9, 32'(i1_irdy), 32'd0);
    chk("d1_odat", 9, 32'(i1_odat), 32'h9C);
    @(negedge clk); i1_ordy = 1'b1; #1;
    chk("d1_irdy", 10, 32'(i1_irdy), 32'd1);
    chk("d1_odat", 10, 32'(i1_odat), 32'h9C);
    @(negedge clk); i1_ivld = 1'b0; #1;
    chk("d1_ovld", 11, 32'(i1_ovld), 32'd1);
    chk("d1_odat", 11, 32'(i1_odat), 32'h9D);

    // DELAY=0: same-cycle pass-through
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i0_ivld = k[0]; i0_ordy = k[1]; i0_idat = 8'(8'h10 * k + 3);
      #1;
      chk("d0_irdy", k, 32'(i0_irdy), 32'(k[1]));
      chk("d0_ovld", k, 32'(i0_ovld), 32'(k[0]));
      chk("d0_odat", k, 32'(i0_odat), 32'(8'h10 * k + 3));
      chk("d0_ocnt", k, 32'(i0_ocnt), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
